tart_visibility_framer: RTL and testbench
=========================================

// Module: tart_visibility_framer
// PURPOSE
//  Host-side consumer of the correlator's visibility AXI4-Stream (re/im pairs, ACCUM bits each, `last` on the final sum).
//  Accepts one visibility at a time and checks the frame length against TOTAL.
//  Serialises each frame into an 8-bit AXI4-Stream for the USB/SPI host link: header, payload, XOR checksum.
//  Sits in the bus-clock domain, directly downstream of the correlator's output port.
// PARAMETERS
//  ACCUM   36     bit-width of each visibility component (re, im), two's complement
//  TOTAL   540    visibilities per frame (CORES*TRATE)
//  NBITS   10     width of visibility index counter, >= clog2(TOTAL+1)
//  HEADER  8'hA5  sync byte opening every frame
//  (local) BYTES = (ACCUM+7)/8 bytes per component; each component is sign-extended to 8*BYTES bits
// PORTS
//  clock_i        in   1       bus clock; the only clock
//  reset_i        in   1       synchronous, active-high reset
//  enable_i       in   1       permit start of a new frame
//  vis_revis_i    in   ACCUM   visibility real part
//  vis_imvis_i    in   ACCUM   visibility imaginary part
//  vis_valid_i    in   1       AXIS tvalid (visibility)
//  vis_ready_o    out  1       AXIS tready (visibility)
//  vis_last_i     in   1       AXIS tlast, final visibility of frame
//  m_tdata_o      out  8       host byte stream data
//  m_tvalid_o     out  1       host byte stream valid
//  m_tready_i     in   1       host byte stream ready
//  m_tlast_o      out  1       marks checksum byte (end of frame)
//  frame_count_o  out  8       frames completed, wraps 255->0
//  len_err_o      out  1       sticky: a frame length mismatch occurred
//  busy_o         out  1       state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; vis_ready_o=0; m_tvalid_o=0; m_tlast_o=0; m_tdata_o=0; frame_count_o=0; len_err_o=0; index=0; csum=0.
//  All outputs are registered. Byte handshake: a byte transfers when m_tvalid_o & m_tready_i.
//  While m_tvalid_o=1 and m_tready_i=0, m_tdata_o and m_tlast_o hold stable.
//  FSM:
//   IDLE: when enable_i & vis_valid_i -> HDR. No input is consumed. enable_i is sampled only in IDLE.
//   HDR: emit HEADER, then frame_count_o -> LOAD.
//   LOAD: vis_ready_o=1.
//    On input handshake: capture {sext(im),sext(re)} into a 16*BYTES-bit shift register; capture last; index+=1.
//    Then vis_ready_o=0 on the next cycle -> DATA. At most one visibility is held.
//   DATA: emit re bytes LSB-first, then im bytes LSB-first, 2*BYTES bytes in total. After the final byte handshake:
//    last & index==TOTAL -> CSUM (normal end)
//    last & index!=TOTAL -> CSUM, set len_err_o (short frame)
//    !last & index==TOTAL -> CSUM, set len_err_o (missing last). The next visibility opens a new frame.
//    else -> LOAD
//   CSUM: emit csum with m_tlast_o=1. On handshake: frame_count_o+=1, index=0, csum=0 -> IDLE.
//  csum = XOR of every byte emitted in the frame, header bytes included. It updates on each byte handshake.
//  Sign extension: bits [8*BYTES-1:ACCUM] = bit ACCUM-1 of the component.
//  Latency: input handshake -> first payload byte valid = 1 cycle. With m_tready_i=1, a frame lasts 2+TOTAL*(2*BYTES+2)+1 cycles.
//  Throughput: one output byte per cycle, sustained within a visibility.
//  vis_ready_o is never 1 outside LOAD. The upstream core keeps valid/data stable until it sees ready.
//  Reset mid-frame: everything returns to reset values on the next edge. The partial frame is dropped without tlast.
//  frame_count_o is also cleared by reset.
//  index saturates logically at TOTAL; NBITS must hold TOTAL.
// TESTING
//  T1 TOTAL=4, ACCUM=36, m_tready=1: 4 vis re=k, im=-k (k=1..4), last on 4th
//   -> 43 bytes: A5,00, then 01 00 00 00 00 FF FF FF FF FF ...; tlast only on byte 43 = XOR of bytes 1..42; frame_count=1.
//  T2 same stimulus, m_tready random 50%, vis_valid random
//   -> byte sequence identical to T1; tdata stable during every stall; no input lost.
//  T3 last on 2nd vis -> 2+20+1=23 bytes, tlast on 23rd, len_err_o=1, frame_count=1.
//   A following good frame is emitted normally with header byte 01.
//  T4 6 vis, no last -> frame 0 closes after vis 4 with len_err_o=1.
//   Vis 5-6 begin frame 1 (A5,01); vis_ready stays 0 in IDLE when enable_i=0.
//  T5 reset_i asserted for 1 cycle during DATA byte 3 -> next cycle m_tvalid=0, vis_ready=0, busy=0.
//   The next frame header is A5,00.
//  T6 re=36'h8_0000_0001, im=36'h7_FFFF_FFFF -> payload 01 00 00 00 F8 FF FF FF FF 07.

Source files
------------

// File: rtl/tart_visibility_framer.sv
// tart_visibility_framer: frames correlator visibilities into a header/payload/XOR-checksum byte stream.
// Revision 1.0
`default_nettype none

module tart_visibility_framer #(
  parameter int          ACCUM  = 36,
  parameter int          TOTAL  = 540,
  parameter int          NBITS  = 10,
  parameter logic [7:0]  HEADER = 8'hA5
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic [ACCUM-1:0] vis_revis_i,
  input  logic [ACCUM-1:0] vis_imvis_i,
  input  logic             vis_valid_i,
  output logic             vis_ready_o,
  input  logic             vis_last_i,
  output logic [7:0]       m_tdata_o,
  output logic             m_tvalid_o,
  input  logic             m_tready_i,
  output logic             m_tlast_o,
  output logic [7:0]       frame_count_o,
  output logic             len_err_o,
  output logic             busy_o
);

  localparam int BYTES = (ACCUM + 7) / 8;
  localparam int CW    = 8 * BYTES;
  localparam int BCW   = $clog2(2 * BYTES + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    LOAD = 3'd2,
    DATA = 3'd3,
    CSUM = 3'd4
  } state_t;

  state_t              state;
  logic [2*CW-1:0]     shreg;
  logic                last_held;
  logic                hdr_second;
  logic [NBITS-1:0]    index;
  logic [7:0]          csum;
  logic [BCW-1:0]      bcnt;

  logic                xfer;
  logic                at_total;
  logic [CW-1:0]       re_ext;
  logic [CW-1:0]       im_ext;

  assign xfer     = m_tvalid_o & m_tready_i;
  assign at_total = (index == NBITS'(TOTAL));
  assign re_ext   = CW'($signed(vis_revis_i));
  assign im_ext   = CW'($signed(vis_imvis_i));

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state         <= IDLE;
      vis_ready_o   <= 1'b0;
      m_tvalid_o    <= 1'b0;
      m_tlast_o     <= 1'b0;
      m_tdata_o     <= 8'd0;
      frame_count_o <= 8'd0;
      len_err_o     <= 1'b0;
      busy_o        <= 1'b0;
      index         <= '0;
      csum          <= 8'd0;
      shreg         <= '0;
      last_held     <= 1'b0;
      hdr_second    <= 1'b0;
      bcnt          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable_i && vis_valid_i) begin
            state      <= HDR;
            m_tvalid_o <= 1'b1;
            m_tdata_o  <= HEADER;
            hdr_second <= 1'b0;
            busy_o     <= 1'b1;
          end
        end
        HDR: begin
          if (xfer) begin
            csum <= csum ^ m_tdata_o;
            if (!hdr_second) begin
              m_tdata_o  <= frame_count_o;
              hdr_second <= 1'b1;
            end else begin
              m_tvalid_o <= 1'b0;
              state      <= LOAD;
            end
          end
        end
        // Ready rises one cycle after entering LOAD and drops right after the capture.
        LOAD: begin
          if (!vis_ready_o) begin
            vis_ready_o <= 1'b1;
          end else if (vis_valid_i) begin
            vis_ready_o <= 1'b0;
            shreg       <= {im_ext, re_ext} >> 8;
            m_tdata_o   <= re_ext[7:0];
            m_tvalid_o  <= 1'b1;
            last_held   <= vis_last_i;
            bcnt        <= '0;
            if (!at_total) index <= index + 1'b1;
            state       <= DATA;
          end
        end
        DATA: begin
          if (xfer) begin
            csum <= csum ^ m_tdata_o;
            if (bcnt == BCW'(2 * BYTES - 1)) begin
              if (last_held || at_total) begin
                len_err_o <= len_err_o | (last_held != at_total);
                m_tdata_o <= csum ^ m_tdata_o;
                m_tlast_o <= 1'b1;
                state     <= CSUM;
              end else begin
                m_tvalid_o <= 1'b0;
                state      <= LOAD;
              end
            end else begin
              m_tdata_o <= shreg[7:0];
              shreg     <= shreg >> 8;
              bcnt      <= bcnt + 1'b1;
            end
          end
        end
        CSUM: begin
          if (xfer) begin
            m_tvalid_o    <= 1'b0;
            m_tlast_o     <= 1'b0;
            frame_count_o <= frame_count_o + 8'd1;
            index         <= '0;
            csum          <= 8'd0;
            busy_o        <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tart_visibility_framer.sv
// tb_tart_visibility_framer: scoreboard bench with a frame-level reference model.
`default_nettype none

module tb_tart_visibility_framer;

  localparam int ACCUM = 36;
  localparam int TOTAL = 4;
  localparam int NBITS = 10;
  localparam int BYTES = (ACCUM + 7) / 8;

  logic             clock_i = 1'b0;
  logic             reset_i;
  logic             enable_i;
  logic [ACCUM-1:0] vis_revis_i;
  logic [ACCUM-1:0] vis_imvis_i;
  logic             vis_valid_i;
  logic             vis_ready_o;
  logic             vis_last_i;
  logic [7:0]       m_tdata_o;
  logic             m_tvalid_o;
  logic             m_tready_i;
  logic             m_tlast_o;
  logic [7:0]       frame_count_o;
  logic             len_err_o;
  logic             busy_o;

  always #5 clock_i = ~clock_i;

  tart_visibility_framer #(
    .ACCUM(ACCUM), .TOTAL(TOTAL), .NBITS(NBITS), .HEADER(8'hA5)
  ) dut (
    .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i),
    .vis_revis_i(vis_revis_i), .vis_imvis_i(vis_imvis_i),
    .vis_valid_i(vis_valid_i), .vis_ready_o(vis_ready_o), .vis_last_i(vis_last_i),
    .m_tdata_o(m_tdata_o), .m_tvalid_o(m_tvalid_o), .m_tready_i(m_tready_i),
    .m_tlast_o(m_tlast_o), .frame_count_o(frame_count_o),
    .len_err_o(len_err_o), .busy_o(busy_o)
  );

  int total = 0;
  int bad   = 0;

  // Expected bytes as {tlast, data}
  logic [8:0] expq[$];

  int         m_idx  = 0;
  bit         m_open = 0;
  bit         m_err  = 0;
  logic [7:0] m_fc   = 8'd0;
  logic [7:0] m_csum = 8'd0;
  bit         rand_ready = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push_byte(input logic [7:0] b);
    expq.push_back({1'b0, b});
    m_csum ^= b;
  endfunction

  // Frame rules: open with A5 + frame number, ten payload bytes per visibility,
  // close on last or on reaching TOTAL, flagging any disagreement between the two.
  function automatic void model_vis(input logic [ACCUM-1:0] re, input logic [ACCUM-1:0] im,
                                    input bit last);
    logic signed [ACCUM-1:0] sr;
    logic signed [ACCUM-1:0] si;
    longint vr;
    longint vi;
    if (!m_open) begin
      m_open = 1;
      m_csum = 8'd0;
      push_byte(8'hA5);
      push_byte(m_fc);
    end
    sr = re;
    si = im;
    vr = sr;
    vi = si;
    for (int i = 0; i < BYTES; i++) push_byte(8'(vr >>> (8 * i)));
    for (int i = 0; i < BYTES; i++) push_byte(8'(vi >>> (8 * i)));
    m_idx++;
    if (last || m_idx == TOTAL) begin
      if (last != (m_idx == TOTAL)) m_err = 1;
      expq.push_back({1'b1, m_csum});
      m_fc++;
      m_open = 0;
      m_idx  = 0;
    end
  endfunction

  initial begin
    m_tready_i = 1'b1;
    forever begin
      @(posedge clock_i);
      #1;
      m_tready_i = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  int         cyc = 0;
  bit         prev_stall = 0;
  logic [8:0] prev_byte;
  int         fr_start = -1;
  int         last_len = 0;

  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clock_i);
      cyc++;
      if (reset_i) begin
        prev_stall = 0;
        fr_start   = -1;
      end else begin
        if (prev_stall) begin
          chk("stall_valid", m_tvalid_o, 1);
          chk("stall_hold", {m_tlast_o, m_tdata_o}, prev_byte);
        end
        if (vis_ready_o) chk("ready_only_when_busy", busy_o, 1);
        if (m_tvalid_o && fr_start < 0) fr_start = cyc;
        if (m_tvalid_o && m_tready_i) begin
          if (expq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_byte: got %0h expected none", {m_tlast_o, m_tdata_o});
          end else begin
            e = expq.pop_front();
            chk("byte", {m_tlast_o, m_tdata_o}, e);
          end
          if (m_tlast_o) begin
            last_len = cyc - fr_start + 1;
            fr_start = -1;
          end
        end
        prev_stall = m_tvalid_o && !m_tready_i;
        prev_byte  = {m_tlast_o, m_tdata_o};
      end
    end
  end

  task automatic send_vis(input logic [ACCUM-1:0] re, input logic [ACCUM-1:0] im,
                          input bit last, input bit jitter, input bit gate);
    int n;
    if (jitter) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clock_i);
        #1;
      end
    end
    model_vis(re, im, last);
    vis_revis_i = re;
    vis_imvis_i = im;
    vis_last_i  = last;
    vis_valid_i = 1'b1;
    if (gate) begin
      enable_i = 1'b0;
      n = 0;
      while (busy_o && n < 500) begin
        @(negedge clock_i);
        n++;
      end
      chk("gated_idle", busy_o, 0);
      for (int k = 0; k < 8; k++) begin
        @(negedge clock_i);
        chk("gated_ready", vis_ready_o, 0);
        chk("gated_busy", busy_o, 0);
      end
      @(posedge clock_i);
      #1;
      enable_i = 1'b1;
    end
    n = 0;
    do begin
      @(negedge clock_i);
      n++;
    end while (!vis_ready_o && n < 2000);
    chk("vis_accept", vis_ready_o, 1);
    @(posedge clock_i);
    #1;
    vis_valid_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((expq.size() != 0 || busy_o) && n < 3000) begin
      @(negedge clock_i);
      n++;
    end
    chk({tag, "_drained"}, expq.size(), 0);
    chk({tag, "_frame_count"}, frame_count_o, m_fc);
    chk({tag, "_len_err"}, len_err_o, m_err);
    @(posedge clock_i);
    #1;
  endtask

  function automatic logic [ACCUM-1:0] rnd36();
    return ACCUM'({$urandom, $urandom});
  endfunction

  initial begin
    int pos;
    reset_i     = 1'b1;
    enable_i    = 1'b0;
    vis_valid_i = 1'b0;
    vis_last_i  = 1'b0;
    vis_revis_i = '0;
    vis_imvis_i = '0;
    repeat (3) @(posedge clock_i);
    @(negedge clock_i);
    chk("rst_tvalid", m_tvalid_o, 0);
    chk("rst_ready", vis_ready_o, 0);
    chk("rst_tlast", m_tlast_o, 0);
    chk("rst_tdata", m_tdata_o, 0);
    chk("rst_frame_count", frame_count_o, 0);
    chk("rst_len_err", len_err_o, 0);
    chk("rst_busy", busy_o, 0);
    @(posedge clock_i);
    #1;
    reset_i  = 1'b0;
    enable_i = 1'b1;

    // Basic frame, full-rate sink
    for (int k = 1; k <= 4; k++) send_vis(ACCUM'(k), ACCUM'(-k), k == 4, 0, 0);
    drain("t1");
    chk("t1_frame_cycles", last_len, 2 + TOTAL * (2 * BYTES + 2) + 1);

    // Same frame with back-pressure and gappy input
    rand_ready = 1;
    for (int k = 1; k <= 4; k++) send_vis(ACCUM'(k), ACCUM'(-k), k == 4, 1, 0);
    drain("t2");
    rand_ready = 0;

    // Short frame, then a good one
    for (int k = 1; k <= 2; k++) send_vis(ACCUM'(k), ACCUM'(-k), k == 2, 0, 0);
    drain("t3_short");
    for (int k = 1; k <= 4; k++) send_vis(ACCUM'(k * 3), ACCUM'(-k), k == 4, 0, 0);
    drain("t3_good");

    // Missing last: auto-close at TOTAL, next visibility waits for enable
    for (int k = 1; k <= 4; k++) send_vis(ACCUM'(k), ACCUM'(k + 7), 0, 0, 0);
    send_vis(ACCUM'(5), ACCUM'(-5), 0, 0, 1);
    send_vis(ACCUM'(6), ACCUM'(-6), 0, 0, 0);
    send_vis(ACCUM'(7), ACCUM'(-7), 0, 0, 0);
    send_vis(ACCUM'(8), ACCUM'(-8), 1, 0, 0);
    drain("t4");

    // Sign-extension corner values
    send_vis(36'h8_0000_0001, 36'h7_FFFF_FFFF, 0, 0, 0);
    for (int k = 0; k < 3; k++) send_vis(rnd36(), rnd36(), k == 2, 0, 0);
    drain("t6");

    // Random frames of random length under back-pressure
    rand_ready = 1;
    for (int f = 0; f < 5; f++) begin
      pos = $urandom_range(0, 4);
      for (int j = 0; j < 4; j++) begin
        send_vis(rnd36(), rnd36(), j == pos, 1, 0);
        if (j == pos) break;
      end
    end
    rand_ready = 0;
    drain("t7");

    // Reset in the middle of a payload
    send_vis(ACCUM'(5), ACCUM'(6), 0, 0, 0);
    @(posedge clock_i);
    #1;
    @(posedge clock_i);
    #1;
    reset_i = 1'b1;
    expq.delete();
    @(posedge clock_i);
    #1;
    reset_i = 1'b0;
    m_fc    = 8'd0;
    m_open  = 0;
    m_idx   = 0;
    m_err   = 0;
    m_csum  = 8'd0;
    @(negedge clock_i);
    chk("t5_tvalid", m_tvalid_o, 0);
    chk("t5_ready", vis_ready_o, 0);
    chk("t5_busy", busy_o, 0);
    chk("t5_frame_count", frame_count_o, 0);
    chk("t5_len_err", len_err_o, 0);
    @(posedge clock_i);
    #1;
    for (int k = 1; k <= 4; k++) send_vis(rnd36(), rnd36(), k == 4, 0, 0);
    drain("t5_after");
    chk("end_tvalid", m_tvalid_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
